// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: shared types and constants for the instruction/data memory
// port arbiter.
//   arb_state_e     : arbiter FSM states
//   arb_src_e       : which requester owns the access in flight
//   DEFAULT_MEM_LAT : default memory latency (mem_en cycle through capture edge)
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } arb_src_e;

    localparam int DEFAULT_MEM_LAT = 2;

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter timing one memory access.
//   clk, rst : clock, asynchronous active-low reset
//   load     : load the counter with MEM_LAT (takes precedence over dec)
//   dec      : decrement by one, saturating at zero
//   done     : count equals 1, i.e. this is the read-data capture cycle
module mem_lat_counter
    import mips_arb_pkg::*;
#(
    parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(MEM_LAT);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes the IF-stage fetch port and the MEM-stage data
// port onto one single-ported, fixed-latency memory.
//   clk, rst                     : clock, asynchronous active-low reset
//   if_req/if_addr               : fetch request (held until if_ready)
//   if_rdata/if_ready            : fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata: data request (held until dm_ready)
//   dm_rdata/dm_ready            : read data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
//   stall_if/stall_mem           : pipeline freeze while a request is pending
//   busy                         : FSM not in IDLE
// Optional build macro ARB_FAIR_EN: after MAX_DATA_STREAK back-to-back data
// grants won against a waiting fetch, the fetch is granted once. Without it,
// data always wins and a fetch can starve while dm_req is held.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MEM_LAT         = DEFAULT_MEM_LAT,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy
);

    arb_state_e    state_q, state_d;
    arb_src_e      src_q, src_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          cnt_load, cnt_dec, cnt_done;
    logic          force_if;

`ifdef ARB_FAIR_EN
    localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

    // Data grants won while a fetch was waiting; never exceeds MAX_DATA_STREAK
    // because reaching it forces the next contested grant to IF.
    logic [SW-1:0] streak_q, streak_d;

    assign force_if = if_req && dm_req && (streak_q == SW'(MAX_DATA_STREAK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) streak_q <= '0;
        else      streak_q <= streak_d;
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef ARB_FAIR_EN
        streak_d    = streak_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Data wins ties: it belongs to the older instruction.
                if (dm_req && !force_if) begin
                    state_d     = ACC_D;
                    src_d       = SRC_DM;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_load    = 1'b1;
`ifdef ARB_FAIR_EN
                    streak_d    = if_req ? streak_q + SW'(1) : '0;
`endif
                end else if (if_req) begin
                    // Fetches never write; mem_wdata keeps its last value.
                    state_d     = ACC_I;
                    src_d       = SRC_IF;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    cnt_load    = 1'b1;
`ifdef ARB_FAIR_EN
                    streak_d    = '0;
`endif
                end
            end
            ACC_I, ACC_D: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d = RESP;
                    if (state_q == ACC_I) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            // Always return through IDLE so a request still held during its
            // ready pulse is not granted a second time.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    mem_lat_counter #(
        .MEM_LAT(MEM_LAT)
    ) u_lat (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .dec (cnt_dec),
        .done(cnt_done)
    );

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = (state_q == RESP) && (src_q == SRC_IF);
    assign dm_ready  = (state_q == RESP) && (src_q == SRC_DM);
    assign busy      = (state_q != IDLE);

    // Stalls are gated by rst so every output reads 0 while reset is held,
    // even if a stage keeps its request up.
    assign stall_if  = rst && if_req && !if_ready;
    assign stall_mem = rst && dm_req && !dm_ready;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Accesses are serialized through a small FSM. Each requester receives a one-cycle ready pulse with its read data. Per-port stall signals freeze the pipeline stages while an access is pending, and the block sits between the pipeline core and the unified memory model.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle through the rdata-capture edge; must be ≥1
- MAX_DATA_STREAK, 4, consecutive data grants allowed before IF is forced (fairness only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction, valid when if_ready
- if_ready  out  1  one-cycle completion pulse
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read data, valid when dm_ready
- dm_ready  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT−1 cycles after the mem_en cycle
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  dm_req & ~dm_ready (combinational)
- busy  out  1  FSM not in IDLE

## Operation
- FSM states:
  - IDLE: samples requests.
  - ACC_I / ACC_D: access in flight.
  - RESP: ready pulse.
- IDLE → ACC_D when dm_req, and also when both requests are present (data has priority because it is the older instruction).
- IDLE → ACC_I when only if_req is present.
- Entering ACC_x:
  - Registers mem_addr, mem_we and mem_wdata from the winner.
  - Asserts mem_en for exactly one cycle.
  - Loads the latency counter with MEM_LAT.
- Within ACC_x, the counter decrements each cycle. On the edge where the counter equals 1:
  - For a read, mem_rdata is captured into x_rdata.
  - The FSM moves to RESP.
- RESP:
  - x_ready = 1 for the granted port only.
  - Unconditional transition to IDLE, which creates a one-cycle bubble so a held request is not re-granted.
- Writes pulse dm_ready. dm_rdata holds its previous value.
- if_rdata and dm_rdata hold their values between accesses.
- mem_addr, mem_we and mem_wdata hold their last values outside mem_en. mem_we is forced to 0 for IF grants.
- Requests that drop before completion are undefined (protocol violation). The access still completes.
- Request signals are sampled only in IDLE. Address and data are sampled only at grant.

## Timing
- Request seen in IDLE at cycle t:
  - mem_en at t+1.
  - rdata captured at the end of cycle t+MEM_LAT.
  - ready at t+MEM_LAT+1.
  - IDLE at t+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Reset values: all outputs 0, state IDLE, counter 0, streak 0.
- Reset mid-access: everything clears immediately. The in-flight access is abandoned and no ready pulse is produced. After release, held requests are re-arbitrated from IDLE.

## Configuration
- ARB_FAIR_EN defined:
  - A streak counter increments on each data grant made while if_req=1.
  - It clears on an IF grant, or on a data grant made while if_req=0.
  - In IDLE with both requests present and streak == MAX_DATA_STREAK, IF is granted.
- ARB_FAIR_EN undefined: strict data priority; IF can starve while dm_req is held. No streak logic is present.

## Structure
- Package mips_arb_pkg:
  - State enum (IDLE, ACC_I, ACC_D, RESP).
  - Grant-source encoding (SRC_IF, SRC_DM).
  - Default MEM_LAT constant.
- Sub-module mem_lat_counter:
  - Loadable down-counter with a done flag at count 1.
  - Width $clog2(MEM_LAT+1).

## Test plan
All scenarios use MEM_LAT=2.
1. IF read: if_req with addr 0x40 at cycle 0, memory returns 0x8C220004 → mem_en=1, mem_we=0, mem_addr=0x40 at cycle 1; if_ready=1 with if_rdata=0x8C220004 at cycle 3; stall_if=1 during cycles 0–2.
2. Both requests at cycle 0 (dm read 0x20 → 0x11, IF 0x44 → 0x22) → dm_ready at cycle 3; second mem_en (IF) at cycle 5; if_ready with 0x22 at cycle 7.
3. Data write: addr 0x10, wdata 0xDEADBEEF → mem_we=1 and mem_wdata=0xDEADBEEF at cycle 1; dm_ready at cycle 3; dm_rdata unchanged.
4. Both requests held continuously:
   - With ARB_FAIR_EN: grants D,D,D,D,I,D,…
   - Without ARB_FAIR_EN: no if_ready within 40 cycles.
5. rst low at cycle 2 of an IF access → all outputs 0 immediately; no if_ready. After release, the held if_req yields mem_en 1 cycle later and if_ready MEM_LAT+1 cycles after release.
6. Back-to-back IF requests held → successive mem_en pulses exactly 4 cycles apart; busy is low one cycle between accesses.
